// File: rtl/systolic_result_writer.sv
// Snapshots an 8x8 result tile on start and streams it to memory as row-major BANDWIDTH-lane beats.
// Optional build macro WRITER_RELU_EN zeroes every lane whose sign bit is set.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 4
`endif

module systolic_result_writer_lane #(
  parameter int K         = 0,
  parameter int DW        = 32,
  parameter int TILE_COLS = 8,
  parameter int CI        = 3
) (
  input  logic [TILE_COLS-1:0][DW-1:0] row,
  input  logic [CI-1:0]                col,
  input  logic [3:0]                   ncols,
  output logic [DW-1:0]                data,
  output logic                         mask
);
  logic [CI-1:0] idx;
  logic [DW-1:0] word;

  // TILE_COLS is a multiple of the lane count, so col+K never leaves the row
  assign idx  = col + CI'(K);
  assign mask = (int'(col) + K) < int'(ncols);
  assign word = row[idx];
`ifdef WRITER_RELU_EN
  assign data = (mask && !word[DW-1]) ? word : '0;
`else
  assign data = mask ? word : '0;
`endif
endmodule

module systolic_result_writer #(
  parameter int TILE_ROWS = 8,
  parameter int TILE_COLS = 8
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            start,
  input  logic [TILE_ROWS-1:0][TILE_COLS-1:0][`DATA_WIDTH-1:0] tile,
  input  logic [`ADDR_WIDTH-1:0]                          base_C,
  input  logic [`DIM_WIDTH-1:0]                           dim_col_C,
  input  logic [3:0]                                      num_rows,
  input  logic [3:0]                                      num_cols,
  output logic                                            write,
  output logic [`ADDR_WIDTH-1:0]                          write_addr,
  output logic [`BANDWIDTH-1:0][`DATA_WIDTH-1:0]          write_data,
  output logic [`BANDWIDTH-1:0]                           write_mask,
  input  logic                                            write_ready,
  output logic                                            busy,
  output logic                                            done
);
  localparam int DW = `DATA_WIDTH;
  localparam int AW = `ADDR_WIDTH;
  localparam int B  = `BANDWIDTH;
  localparam int RI = $clog2(TILE_ROWS);
  localparam int CI = $clog2(TILE_COLS);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  typedef logic [TILE_ROWS-1:0][TILE_COLS-1:0][DW-1:0] tile_t;

  state_t                 state, nxt_state;
  tile_t                  tile_q, nxt_tile;
  logic [AW-1:0]          row_addr, nxt_row_addr;
  logic [`DIM_WIDTH-1:0]  dim_q, nxt_dim;
  logic [3:0]             nrows_q, ncols_q, nxt_nrows, nxt_ncols;
  logic [RI-1:0]          r_q, nxt_r;
  logic [CI-1:0]          c_q, nxt_c;
  logic                   row_end, last_beat;
  logic [B-1:0][DW-1:0]   lane_data;
  logic [B-1:0]           lane_mask;

  function automatic logic [3:0] clamp(input logic [3:0] n, input int lim);
    return (n == 4'd0 || int'(n) > lim) ? 4'(lim) : n;
  endfunction

  assign row_end   = (int'(c_q) + B) >= int'(ncols_q);
  assign last_beat = row_end && (int'(r_q) == int'(nrows_q) - 1);

  always_comb begin
    nxt_state    = state;
    nxt_tile     = tile_q;
    nxt_row_addr = row_addr;
    nxt_dim      = dim_q;
    nxt_nrows    = nrows_q;
    nxt_ncols    = ncols_q;
    nxt_r        = r_q;
    nxt_c        = c_q;
    unique case (state)
      IDLE: if (start) begin
        nxt_state    = WRITE;
        nxt_tile     = tile;
        nxt_row_addr = base_C;
        nxt_dim      = dim_col_C;
        nxt_nrows    = clamp(num_rows, TILE_ROWS);
        nxt_ncols    = clamp(num_cols, TILE_COLS);
        nxt_r        = '0;
        nxt_c        = '0;
      end
      WRITE: if (write_ready) begin
        if (last_beat) nxt_state = DONE;
        else if (row_end) begin
          // stride accumulates per row; modulo-2^AW wrap falls out of the adder width
          nxt_r        = r_q + 1'b1;
          nxt_c        = '0;
          nxt_row_addr = row_addr + AW'(dim_q);
        end else nxt_c = c_q + CI'(B);
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Lanes look at the next beat so the output registers present it one edge later with no bubble.
  for (genvar k = 0; k < B; k++) begin : g_lane
    systolic_result_writer_lane #(.K(k), .DW(DW), .TILE_COLS(TILE_COLS), .CI(CI)) u_lane (
      .row   (nxt_tile[nxt_r]),
      .col   (nxt_c),
      .ncols (nxt_ncols),
      .data  (lane_data[k]),
      .mask  (lane_mask[k])
    );
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      write      <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      write_mask <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt_state;
      write      <= (nxt_state == WRITE);
      busy       <= (nxt_state == WRITE);
      done       <= (nxt_state == DONE);
      write_addr <= (nxt_state == WRITE) ? nxt_row_addr + AW'(nxt_c) : '0;
      write_data <= (nxt_state == WRITE) ? lane_data : '0;
      write_mask <= (nxt_state == WRITE) ? lane_mask : '0;
    end
  end

  // Datapath holds no reset: every field is reloaded by the start that leaves IDLE.
  always_ff @(posedge clock) begin
    tile_q   <= nxt_tile;
    row_addr <= nxt_row_addr;
    dim_q    <= nxt_dim;
    nrows_q  <= nxt_nrows;
    ncols_q  <= nxt_ncols;
    r_q      <= nxt_r;
    c_q      <= nxt_c;
  end
endmodule

// File: tb/tb_systolic_result_writer.sv
// Scoreboard bench for systolic_result_writer: stimulus queues expected beats, a monitor pops and compares.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 4
`endif

module tb_systolic_result_writer;
  localparam int TR = 8, TC = 8;
  localparam int DW = `DATA_WIDTH, AW = `ADDR_WIDTH, B = `BANDWIDTH;
  typedef logic [TR-1:0][TC-1:0][DW-1:0] tile_t;
  typedef struct {
    logic [AW-1:0]        addr;
    logic [B-1:0][DW-1:0] data;
    logic [B-1:0]         mask;
  } beat_t;

  logic clock = 1'b0, reset = 1'b0, start = 1'b0, write_ready = 1'b1;
  tile_t tile = '0;
  logic [AW-1:0] base_C = '0;
  logic [`DIM_WIDTH-1:0] dim_col_C = '0;
  logic [3:0] num_rows = '0, num_cols = '0;
  logic write, busy, done;
  logic [AW-1:0] write_addr;
  logic [B-1:0][DW-1:0] write_data;
  logic [B-1:0] write_mask;

  int checks = 0, failures = 0, done_cnt = 0;
  beat_t exp_q[$];
  logic [AW-1:0] acc_addr[$];
  logic [DW-1:0] mem[int];
  bit stall_prev = 1'b0;
  beat_t held;
  tile_t full;

  always #5 clock = ~clock;

  systolic_result_writer dut (
    .clock(clock), .reset(reset), .start(start), .tile(tile), .base_C(base_C),
    .dim_col_C(dim_col_C), .num_rows(num_rows), .num_cols(num_cols), .write(write),
    .write_addr(write_addr), .write_data(write_data), .write_mask(write_mask),
    .write_ready(write_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // IEEE single for small non-negative integers
  function automatic logic [31:0] f32(input int n);
    int e;
    if (n == 0) return 32'h0;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h7F_FFFF)};
  endfunction

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
`ifdef WRITER_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  task automatic expect_tile(input tile_t t, input int base, input int dim, input int nr, input int nc);
    if (nr == 0 || nr > TR) nr = TR;
    if (nc == 0 || nc > TC) nc = TC;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c += B) begin
        beat_t e;
        e.addr = AW'(base + r * dim + c);
        e.data = '0;
        e.mask = '0;
        for (int k = 0; k < B; k++)
          if (c + k < nc) begin
            e.mask[k] = 1'b1;
            e.data[k] = relu(t[r][c + k]);
          end
        exp_q.push_back(e);
      end
  endtask

  // Monitor: a beat presented with ready high at the negedge is accepted at the next posedge.
  initial forever begin
    @(negedge clock);
    if (reset && stall_prev) begin
      chk("stall_write", write, 1);
      chk("stall_addr", write_addr, held.addr);
      chk("stall_data", write_data, held.data);
      chk("stall_mask", write_mask, held.mask);
    end
    stall_prev = reset && write && !write_ready;
    held.addr = write_addr;
    held.data = write_data;
    held.mask = write_mask;
    if (reset && write && write_ready) begin
      acc_addr.push_back(write_addr);
      for (int k = 0; k < B; k++)
        if (write_mask[k]) begin
          logic [AW-1:0] a;
          a = write_addr + AW'(k);
          mem[int'(a)] = write_data[k];
        end
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual_addr=%0d required=no beat", write_addr);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_addr", write_addr, e.addr);
        chk("beat_data", write_data, e.data);
        chk("beat_mask", write_mask, e.mask);
      end
    end
    if (reset && done) done_cnt++;
  end

  task automatic run(input tile_t t, input int base, input int dim, input int nr, input int nc,
                     input int exp_edges, input int stall_at = -1, input int stall_len = 0,
                     input bit scramble = 1'b0, input int restart_at = -1);
    int edges;
    expect_tile(t, base, dim, nr, nc);
    tile = t; base_C = AW'(base); dim_col_C = `DIM_WIDTH'(dim);
    num_rows = 4'(nr); num_cols = 4'(nc); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    edges = 0;
    chk("busy_after_start", busy, 1);
    while (edges < 200) begin
      if (edges == stall_at) write_ready = 1'b0;
      if (edges == stall_at + stall_len) write_ready = 1'b1;
      start = (edges == restart_at);
      if (start) base_C = AW'(base + 1000);
      if (scramble) begin
        for (int r = 0; r < TR; r++)
          for (int c = 0; c < TC; c++) tile[r][c] = $urandom;
        base_C = AW'($urandom); num_rows = 4'($urandom); num_cols = 4'($urandom);
      end
      @(posedge clock); #1;
      edges++;
      if (done) break;
    end
    start = 1'b0; write_ready = 1'b1;
    chk("done_latency", edges, exp_edges);
    chk("busy_in_done", busy, 0);
    chk("write_in_done", write, 0);
    @(posedge clock); #1;
    chk("done_one_cycle", done, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    tile_t rv;
    bit bad;
    for (int r = 0; r < TR; r++)
      for (int c = 0; c < TC; c++) full[r][c] = f32(r * 8 + c);

    repeat (2) @(posedge clock);
    #1;
    chk("rst_write", write, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_addr", write_addr, 0); chk("rst_data", write_data, 0); chk("rst_mask", write_mask, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // full tile, ready always high
    acc_addr.delete(); mem.delete();
    run(full, 200, 8, 8, 8, 16);
    chk("full_beats", acc_addr.size(), 16);
    chk("full_addr1", acc_addr[1], 204);
    chk("full_addr15", acc_addr[15], 260);
    chk("full_w0", mem[200], 32'h0000_0000);
    chk("full_w3", mem[203], 32'h4040_0000);
    chk("full_w2", mem[202], 32'h4000_0000);
    chk("full_w63", mem[263], 32'h427C_0000);

    // backpressure on beat 5 for three cycles
    acc_addr.delete();
    run(full, 200, 8, 8, 8, 19, 5, 3);
    chk("bp_beats", acc_addr.size(), 16);
    chk("bp_addr5", acc_addr[5], 220);

    // edge tile with odd stride
    acc_addr.delete(); mem.delete();
    run(full, 0, 13, 3, 5, 6);
    chk("edge_beats", acc_addr.size(), 6);
    chk("edge_a1", acc_addr[1], 4); chk("edge_a2", acc_addr[2], 13);
    chk("edge_a3", acc_addr[3], 17); chk("edge_a5", acc_addr[5], 30);
    chk("edge_w4", mem[4], 32'h4080_0000);
    chk("edge_w13", mem[13], 32'h4100_0000);
    bad = 1'b0;
    for (int a = 5; a <= 12; a++) if (mem.exists(a)) bad = 1'b1;
    for (int a = 18; a <= 25; a++) if (mem.exists(a)) bad = 1'b1;
    chk("edge_untouched", bad, 0);

    // address wraps modulo 2^AW
    acc_addr.delete();
    run(full, (1 << AW) - 6, 8, 2, 4, 2);
    chk("wrap_addr", acc_addr[1], 2);

    // second start while busy is ignored
    run(full, 200, 8, 8, 8, 16, -1, 0, 1'b0, 3);

    // reset mid-operation
    expect_tile(full, 200, 8, 8, 8);
    tile = full; base_C = 200; dim_col_C = 8; num_rows = 8; num_cols = 8; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clock); #1; end
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midrst_write", write, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pending", exp_q.size(), 9);
    exp_q.delete();
    d0 = done_cnt;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (10) begin @(posedge clock); #1; end
    chk("midrst_no_done", done_cnt, d0);
    run(full, 200, 8, 8, 8, 16);

    // snapshot: inputs scrambled after start; 0 rows / 15 cols clamp to full tile
    run(full, 300, 8, 0, 15, 16, -1, 0, 1'b1);

    // sign-bit lanes
    rv = '0;
    rv[0][0] = 32'hC020_0000; rv[0][1] = 32'h8000_0000;
    rv[0][2] = 32'h3F80_0000; rv[0][3] = 32'hFFC0_0000;
    mem.delete();
    run(rv, 500, 8, 1, 4, 1);
`ifdef WRITER_RELU_EN
    chk("relu_neg", mem[500], 32'h0); chk("relu_negzero", mem[501], 32'h0);
`else
    chk("relu_neg", mem[500], 32'hC020_0000); chk("relu_negzero", mem[501], 32'h8000_0000);
`endif
    chk("relu_pos", mem[502], 32'h3F80_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
